// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: runs each load/store as a req/ack bus transaction,
// holding the pipeline via o_stall_req until the access completes or times out.
module lsu_mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_DM,
  input  logic [31:0] i_alu_result_DM,
  input  logic [31:0] i_rs2_data_DM,
  input  logic        i_lsu_wren_DM,
  input  logic [1:0]  i_wb_sel_DM,
  input  logic [2:0]  i_funct3_DM,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall_req,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        bus_err_q, bus_err_d;

  logic        access, misaligned, stall, mis_now;
  logic [3:0]  st_bmask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // A store wins when both store and load are flagged.
  assign access  = i_valid_DM & (i_lsu_wren_DM | (i_wb_sel_DM == 2'b01));
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    misaligned = 1'b0;
    st_bmask   = 4'b1111;
    st_wdata   = i_rs2_data_DM;
    unique case (i_funct3_DM[1:0])
      2'b00: begin
        st_bmask = 4'b0001 << i_alu_result_DM[1:0];
        st_wdata = {4{i_rs2_data_DM[7:0]}};
      end
      2'b01: begin
        misaligned = i_alu_result_DM[0];
        st_bmask   = 4'b0011 << {i_alu_result_DM[1], 1'b0};
        st_wdata   = {2{i_rs2_data_DM[15:0]}};
      end
      default: misaligned = |i_alu_result_DM[1:0];
    endcase
  end

  always_comb begin
    ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    mis_now    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (access) begin
          if (misaligned) begin
            mis_now = 1'b1;
          end else begin
            stall    = 1'b1;
            req_d    = 1'b1;
            we_d     = i_lsu_wren_DM;
            addr_d   = {i_alu_result_DM[31:2], 2'b00};
            wdata_d  = i_lsu_wren_DM ? st_wdata : 32'd0;
            bmask_d  = i_lsu_wren_DM ? st_bmask : 4'b1111;
            funct3_d = i_funct3_DM;
            off_d    = i_alu_result_DM[1:0];
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (i_mem_ack) begin
          req_d      = 1'b0;
          state_d    = DONE;
          ld_valid_d = ~we_q;
          if (!we_q) ld_data_d = ld_ext;
        end else if (cnt_inc == MAX_WAIT_C) begin
          req_d      = 1'b0;
          state_d    = DONE;
          bus_err_d  = 1'b1;
          ld_valid_d = ~we_q;
          if (!we_q) ld_data_d = 32'd0;
        end
      end
      // Inputs still describe the finished instruction here; never re-issue it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      bmask_q    <= 4'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bmask_q    <= bmask_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_mem_req    = req_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_bmask  = bmask_q;
  assign o_stall_req  = stall;
  assign o_misaligned = mis_now;
  assign o_ld_valid   = ld_valid_q;
  assign o_ld_data    = mis_now ? 32'd0 : ld_data_q;
  assign o_bus_err    = bus_err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: table of accesses plus hand-written
// back-to-back and reset-during-BUSY sequences.
module tb_lsu_mem_stage;
  localparam logic [31:0] NOISE = 32'h5A5A_A5A5;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid_DM;
  logic [31:0] i_alu_result_DM;
  logic [31:0] i_rs2_data_DM;
  logic        i_lsu_wren_DM;
  logic [1:0]  i_wb_sel_DM;
  logic [2:0]  i_funct3_DM;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_stall_req;
  logic        o_ld_valid;
  logic [31:0] o_ld_data;
  logic        o_misaligned;
  logic        o_bus_err;

  lsu_mem_stage #(.MAX_WAIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_DM(i_valid_DM),
    .i_alu_result_DM(i_alu_result_DM), .i_rs2_data_DM(i_rs2_data_DM),
    .i_lsu_wren_DM(i_lsu_wren_DM), .i_wb_sel_DM(i_wb_sel_DM), .i_funct3_DM(i_funct3_DM),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_stall_req(o_stall_req), .o_ld_valid(o_ld_valid),
    .o_ld_data(o_ld_data), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic        wren;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          waits;       // wait cycles before ack; 255 = never ack
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_bmask;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    int          exp_stall;   // total stall cycles; 0 = no bus access
    logic [31:0] exp_ld_data;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [15];
  vec_t        v2;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int stalls, busy, cyc;
    bit done;
    i_valid_DM      = v.valid;
    i_lsu_wren_DM   = v.wren;
    i_wb_sel_DM     = v.wb_sel;
    i_funct3_DM     = v.funct3;
    i_alu_result_DM = v.addr;
    i_rs2_data_DM   = v.rs2;
    i_mem_ack       = 1'b0;
    i_mem_rdata     = NOISE;
    @(negedge i_clk);
    stalls = int'(o_stall_req);
    chk("misaligned", 32'(o_misaligned), 32'(v.exp_mis));
    chk("idle_req", 32'(o_mem_req), 32'd0);
    if (v.exp_stall == 0) begin
      chk("no_stall", 32'(o_stall_req), 32'd0);
      chk("idle_ld_data", o_ld_data, v.exp_mis ? 32'd0 : last_ld);
      $display("vec %0d addr=0x%08h no access (misaligned=%0b)", idx, v.addr, o_misaligned);
      return;
    end
    busy = 0; done = 0; cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge i_clk); #1;
      i_mem_ack   = 1'b0;
      i_mem_rdata = NOISE;
      cyc++;
      if (o_mem_req) begin
        if (busy == v.waits) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = v.rdata;
        end
        @(negedge i_clk);
        chk("bus_addr", o_mem_addr, v.exp_addr);
        chk("bus_bmask", 32'(o_mem_bmask), 32'(v.exp_bmask));
        chk("bus_we", 32'(o_mem_we), 32'(v.wren));
        if (v.wren) chk("bus_wdata", o_mem_wdata, v.exp_wdata);
        stalls += int'(o_stall_req);
        busy++;
      end else begin
        @(negedge i_clk);
        chk("done_stall", 32'(o_stall_req), 32'd0);
        chk("done_ld_valid", 32'(o_ld_valid), 32'(!v.wren));
        chk("done_ld_data", o_ld_data, v.wren ? last_ld : v.exp_ld_data);
        chk("done_bus_err", 32'(o_bus_err), 32'(v.exp_err));
        done = 1;
      end
    end
    if (!done) chk("done_reached", 32'd0, 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
    if (!v.exp_err) chk("busy_cycles", 32'(busy), 32'(v.waits + 1));
    if (!v.wren) last_ld = v.exp_ld_data;
    $display("vec %0d addr=0x%08h we=%0b busy=%0d stalls=%0d ld_data=0x%08h err=%0b",
             idx, v.addr, v.wren, busy, stalls, o_ld_data, o_bus_err);
  endtask

  initial begin
    //            vld  wren wbsel  f3      addr         rs2           waits rdata          exp_addr     bmask    wdata         mis  stall ld_data        err
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 2, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_0203, 32'h0,        0, 32'h80FF_7F01, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 2, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 3'b100, 32'h0000_0203, 32'h0,        0, 32'h80FF_7F01, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 2, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 3, 32'h0,        32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b0, 5, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0101, 32'h0,        0, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b1, 0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 3'b001, 32'h0000_0003, 32'h0,        0, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b1, 0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 3'b001, 32'h0000_0202, 32'h0,        1, 32'h80FF_7F01, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 3, 32'hFFFF_80FF, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 3'b101, 32'h0000_0200, 32'h0,        0, 32'h80FF_7F01, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 2, 32'h0000_7F01, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 32'h0,        32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 1'b0, 2, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 2, 32'h0,        32'h0000_010C, 4'b1111, 32'hCAFE_F00D, 1'b0, 4, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0300, 32'h0,      255, 32'h1111_1111, 32'h0000_0300, 4'b1111, 32'h0,        1'b0, 5, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_0001, 32'h0,        0, 32'h0000_7F00, 32'h0000_0000, 4'b1111, 32'h0,        1'b0, 2, 32'h0000_007F, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0101, 32'h0,        0, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'b01, 3'b011, 32'h0000_0104, 32'h0,        0, 32'h1234_5678, 32'h0000_0104, 4'b1111, 32'h0,        1'b0, 2, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'b01, 3'b000, 32'h0000_0002, 32'h0000_0011, 0, 32'h0,        32'h0000_0000, 4'b0100, 32'h1111_1111, 1'b0, 2, 32'h0,        1'b0};

    i_rst = 1'b1; i_valid_DM = 1'b0; i_alu_result_DM = 32'd0; i_rs2_data_DM = 32'd0;
    i_lsu_wren_DM = 1'b0; i_wb_sel_DM = 2'b00; i_funct3_DM = 3'd0;
    i_mem_ack = 1'b0; i_mem_rdata = NOISE;
    last_ld = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_bmask", 32'(o_mem_bmask), 32'd0);
    chk("rst_stall", 32'(o_stall_req), 32'd0);
    chk("rst_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("rst_ld_data", o_ld_data, 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(posedge i_clk); #1;
      run_vec(i, vecs[i]);
    end

    // Back-to-back SW then LW, no idle cycle between them.
    v2 = '{1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_0040, 32'h0BAD_CAFE, 0, 32'h0, 32'h0000_0040, 4'b1111, 32'h0BAD_CAFE, 1'b0, 2, 32'h0, 1'b0};
    @(posedge i_clk); #1;
    run_vec(20, v2);
    v2 = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0044, 32'h0, 0, 32'h1357_2468, 32'h0000_0044, 4'b1111, 32'h0, 1'b0, 2, 32'h1357_2468, 1'b0};
    @(posedge i_clk); #1;
    run_vec(21, v2);

    // Reset in the second BUSY cycle; a late ack must be ignored.
    @(posedge i_clk); #1;
    i_valid_DM = 1'b1; i_lsu_wren_DM = 1'b0; i_wb_sel_DM = 2'b01;
    i_funct3_DM = 3'b010; i_alu_result_DM = 32'h0000_0300;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rstbusy_req1", 32'(o_mem_req), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rstbusy_req2", 32'(o_mem_req), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid_DM = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    chk("rstbusy_req_drop", 32'(o_mem_req), 32'd0);
    chk("rstbusy_stall", 32'(o_stall_req), 32'd0);
    chk("rstbusy_ld_valid", 32'(o_ld_valid), 32'd0);
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0; i_mem_rdata = NOISE;
    @(negedge i_clk);
    chk("late_ack_req", 32'(o_mem_req), 32'd0);
    chk("late_ack_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("late_ack_ld_data", o_ld_data, 32'd0);
    chk("late_ack_bus_err", 32'(o_bus_err), 32'd0);
    $display("reset during BUSY: req=%0b stall=%0b ld_valid=%0b", o_mem_req, o_stall_req, o_ld_valid);
    last_ld = 32'd0;
    @(posedge i_clk); #1;
    run_vec(22, vecs[0]);

    @(posedge i_clk); #1;
    i_valid_DM = 1'b0;
    repeat (2) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
